// File: rtl/pxs_pkg.sv
// Shared definitions for the pixel-stream merge path: field layout, combine modes, FSM states.
package pxs_pkg;

    localparam int unsigned STR_W    = 26;
    localparam int unsigned ACTIVE_B = 0;
    localparam int unsigned VS_B     = 1;
    localparam int unsigned HS_B     = 2;
    localparam int unsigned YC_LO    = 3;
    localparam int unsigned YC_HI    = 12;
    localparam int unsigned XC_LO    = 13;
    localparam int unsigned XC_HI    = 22;
    localparam int unsigned RGB_LO   = 23;
    localparam int unsigned RGB_HI   = 25;

    typedef enum logic [1:0] {
        ModeStr1 = 2'b00,
        ModeStr2 = 2'b01,
        ModeAnd  = 2'b10,
        ModeOr   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StSearch  = 2'b00,
        StMeasure = 2'b01,
        StLocked  = 2'b10
    } state_e;

    // Frame start is the first active pixel at the origin, independent of sync polarity.
    function automatic logic is_fs(input logic [STR_W-1:0] s);
        return s[ACTIVE_B] && (s[XC_HI:XC_LO] == '0) && (s[YC_HI:YC_LO] == '0);
    endfunction

    function automatic logic [2:0] combine(input mode_e m, input logic [2:0] a, input logic [2:0] b);
        logic [2:0] r;
        unique case (m)
            ModeStr1: r = a;
            ModeStr2: r = b;
            ModeAnd:  r = a & b;
            ModeOr:   r = a | b;
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pxs_merge2_if.sv
// Stream and status bundle of pxs_merge2; master drives the two input streams, slave is the merger.
interface pxs_merge2_if #(
    parameter int unsigned MAX_SKEW = 64
) ();

    localparam int unsigned SKW_W = $clog2(MAX_SKEW);

    logic [1:0]                  mode_i;
    logic [pxs_pkg::STR_W-1:0]   RGBStr1_i;
    logic [pxs_pkg::STR_W-1:0]   RGBStr2_i;
    logic [pxs_pkg::STR_W-1:0]   RGBStr_o;
    logic                        locked_o;
    logic [SKW_W-1:0]            skew_o;
    logic                        err_o;

    modport master (
        output mode_i, RGBStr1_i, RGBStr2_i,
        input  RGBStr_o, locked_o, skew_o, err_o
    );

    modport slave (
        input  mode_i, RGBStr1_i, RGBStr2_i,
        output RGBStr_o, locked_o, skew_o, err_o
    );

endinterface

// File: rtl/pxs_delay_buf.sv
// Circular alignment buffer: writes every cycle, reads skew_i entries back; skew 0 bypasses the RAM.
module pxs_delay_buf
    import pxs_pkg::*;
#(
    parameter int unsigned Depth = 64,
    localparam int unsigned PtrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [STR_W-1:0] din_i,
    input  logic [PtrW-1:0]  skew_i,
    output logic [STR_W-1:0] dout_o
);

    logic [STR_W-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
        end else begin
            wptr_q <= wptr_q + 1'b1;
        end
    end

    // Contents need no reset: nothing reads them until a skew has been measured.
    always_ff @(posedge clk_i) begin
        mem_q[wptr_q] <= din_i;
    end

    always_comb begin
        if (skew_i == '0) begin
            dout_o = din_i;
        end else begin
            dout_o = mem_q[wptr_q - skew_i];
        end
    end

endmodule

// File: rtl/pxs_merge2.sv
// Re-joins two skewed pixel streams: measures skew at frame start, aligns stream1, merges RGB.
// Optional macro PXS_MERGE_CHECK_EN: drop lock when aligned coordinates disagree.
module pxs_merge2
    import pxs_pkg::*;
#(
    parameter int unsigned MAX_SKEW = 64
) (
    input  logic         px_clk,
    input  logic         rst_n,
    pxs_merge2_if.slave  bus
);

    localparam int unsigned SKW_W = $clog2(MAX_SKEW);

    state_e           state_q;
    logic [SKW_W-1:0] cnt_q;
    logic [SKW_W-1:0] skew_q;
    logic             locked_q;
    logic             err_q;
    logic [STR_W-1:0] out_q;
    logic [STR_W-1:0] out_d;

    logic [STR_W-1:0] str1;
    logic [STR_W-1:0] str2;
    logic [STR_W-1:0] a1;
    logic             fs1;
    logic             fs2;
    logic             chk_mis;
    mode_e            mode;

    assign str1 = bus.RGBStr1_i;
    assign str2 = bus.RGBStr2_i;
    assign mode = mode_e'(bus.mode_i);
    assign fs1  = is_fs(str1);
    assign fs2  = is_fs(str2);

    pxs_delay_buf #(
        .Depth (MAX_SKEW)
    ) u_delay_buf (
        .clk_i  (px_clk),
        .rst_ni (rst_n),
        .din_i  (str1),
        .skew_i (skew_q),
        .dout_o (a1)
    );

`ifdef PXS_MERGE_CHECK_EN
    assign chk_mis = (state_q == StLocked) && str2[ACTIVE_B] &&
                     (a1[XC_HI:YC_LO] != str2[XC_HI:YC_LO]);
`else
    logic unused_a1;
    assign chk_mis   = 1'b0;
    assign unused_a1 = ^a1[XC_HI:0];
`endif

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StSearch;
            cnt_q    <= '0;
            skew_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StSearch: begin
                    if (fs1 && fs2) begin
                        skew_q   <= '0;
                        locked_q <= 1'b1;
                        state_q  <= StLocked;
                    end else if (fs1) begin
                        cnt_q   <= SKW_W'(1);
                        state_q <= StMeasure;
                    end
                end
                StMeasure: begin
                    if (fs2) begin
                        skew_q   <= cnt_q;
                        locked_q <= 1'b1;
                        state_q  <= StLocked;
                    end else if (fs1) begin
                        cnt_q <= SKW_W'(1);
                    end else if (cnt_q == SKW_W'(MAX_SKEW - 1)) begin
                        // Counter would reach MAX_SKEW: skew is beyond what the buffer can hold.
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StSearch;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StLocked: begin
                    if (chk_mis) begin
                        err_q    <= 1'b1;
                        locked_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= StSearch;
                    end
                end
                default: begin
                    state_q  <= StSearch;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        out_d                 = '0;
        out_d[XC_HI:0]        = str2[XC_HI:0];
        if ((state_q == StLocked) && str2[ACTIVE_B] && !chk_mis) begin
            out_d[RGB_HI:RGB_LO] = combine(mode, a1[RGB_HI:RGB_LO], str2[RGB_HI:RGB_LO]);
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.RGBStr_o = out_q;
    assign bus.locked_o = locked_q;
    assign bus.skew_o   = skew_q;
    assign bus.err_o    = err_q;

endmodule

// File: tb/tb_pxs_merge2.sv
// Directed bench for pxs_merge2: combine table at skew 0, skewed raster runs, overflow, mid-reset.
module tb_pxs_merge2;

    localparam int unsigned MAX_SKEW = 64;
    localparam logic [25:0] IDLE2 = {3'b111, 10'd5, 10'd3, 1'b1, 1'b1, 1'b0};

    logic px_clk = 1'b0;
    logic rst_n  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 px_clk = ~px_clk;

    pxs_merge2_if #(.MAX_SKEW(MAX_SKEW)) bus ();

    pxs_merge2 #(
        .MAX_SKEW (MAX_SKEW)
    ) dut (
        .px_clk (px_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [1:0] mode;
        logic [2:0] r1;
        logic [2:0] r2;
        logic       act;
        logic [2:0] exp_rgb;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Synthetic raster: 24x6 total, 16x4 active, frame length 144 cycles.
    function automatic logic [25:0] px(input int n);
        int f;
        int ln;
        int col;
        logic [2:0] rgb;
        f   = n % 144;
        ln  = f / 24;
        col = f % 24;
        rgb = 3'((n * 5) ^ (n >> 2));
        return {rgb, 10'(col), 10'(ln), 1'(col >= 16), 1'(ln >= 4), 1'((ln < 4) && (col < 16))};
    endfunction

    function automatic logic [2:0] ref_comb(input logic [1:0] m, input logic [2:0] a,
                                            input logic [2:0] b);
        case (m)
            2'b00:   return a;
            2'b01:   return b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic drive(input logic [1:0] m, input logic [25:0] s1, input logic [25:0] s2);
        bus.mode_i    = m;
        bus.RGBStr1_i = s1;
        bus.RGBStr2_i = s2;
    endtask

    task automatic step();
        @(posedge px_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(2'b00, '0, '0);
        repeat (2) @(posedge px_clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Stream2 is stream1 delayed by skew with RGB xored by rx; idle blanking pixel before that.
    task automatic run_stream(input string tag, input int skew, input logic [1:0] m,
                              input logic [2:0] rx, input int n_cyc);
        logic [25:0] s1;
        logic [25:0] s2;
        logic [25:0] a1;
        logic [2:0]  rgb;
        for (int t = 0; t < n_cyc; t++) begin
            s1 = px(t);
            a1 = (t >= skew) ? px(t - skew) : '0;
            s2 = (t >= skew) ? (a1 ^ {rx, 23'b0}) : IDLE2;
            drive(m, s1, s2);
            step();
            rgb = (t >= skew + 1 && s2[0]) ? ref_comb(m, a1[25:23], s2[25:23]) : 3'b000;
            chk({tag, " out"}, 32'(bus.RGBStr_o), 32'({rgb, s2[22:0]}));
            chk({tag, " locked"}, 32'(bus.locked_o), 32'(t >= skew));
            chk({tag, " skew"}, 32'(bus.skew_o), (t >= skew) ? 32'(skew) : 32'd0);
            chk({tag, " err"}, 32'(bus.err_o), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{2'b00, 3'b101, 3'b010, 1'b1, 3'b101};
        vecs[1] = '{2'b01, 3'b101, 3'b010, 1'b1, 3'b010};
        vecs[2] = '{2'b10, 3'b110, 3'b011, 1'b1, 3'b010};
        vecs[3] = '{2'b11, 3'b100, 3'b001, 1'b1, 3'b101};
        vecs[4] = '{2'b11, 3'b110, 3'b011, 1'b0, 3'b000};
        vecs[5] = '{2'b10, 3'b111, 3'b111, 1'b1, 3'b111};
        vecs[6] = '{2'b00, 3'b000, 3'b111, 1'b1, 3'b000};
        vecs[7] = '{2'b01, 3'b011, 3'b100, 1'b1, 3'b100};

        // Reset state
        drive(2'b00, '0, '0);
        #3;
        chk("rst out", 32'(bus.RGBStr_o), 32'd0);
        chk("rst locked", 32'(bus.locked_o), 32'd0);
        chk("rst skew", 32'(bus.skew_o), 32'd0);
        chk("rst err", 32'(bus.err_o), 32'd0);
        do_reset();

        // Skew 0: simultaneous frame starts lock immediately, then the combine table
        drive(2'b10, {3'b001, 23'h1}, {3'b001, 23'h1});
        step();
        chk("s0 locked", 32'(bus.locked_o), 32'd1);
        chk("s0 skew", 32'(bus.skew_o), 32'd0);
        chk("s0 first out", 32'(bus.RGBStr_o), 32'h1);
        for (int i = 0; i < 8; i++) begin
            logic [22:0] lo;
            lo = {10'd5, 10'd1, 1'b0, 1'b0, vecs[i].act};
            drive(vecs[i].mode, {vecs[i].r1, lo}, {vecs[i].r2, lo});
            step();
            chk($sformatf("table[%0d]", i), 32'(bus.RGBStr_o), 32'({vecs[i].exp_rgb, lo}));
        end

        do_reset();
        run_stream("skew5", 5, 2'b11, 3'b011, 300);

        do_reset();
        run_stream("skew63", 63, 2'b00, 3'b101, 300);

        // Overflow: FS1 with no FS2 ever
        do_reset();
        for (int t = 0; t < 150; t++) begin
            drive(2'b11, px(t), IDLE2);
            step();
            chk("ovf err", 32'(bus.err_o), 32'(t == 63));
            chk("ovf locked", 32'(bus.locked_o), 32'd0);
            chk("ovf out", 32'(bus.RGBStr_o), 32'({3'b000, IDLE2[22:0]}));
        end

        // Reset in the middle of measurement, then relock on a fresh frame
        do_reset();
        for (int t = 0; t < 20; t++) begin
            drive(2'b01, px(t), IDLE2);
            step();
        end
        chk("pre-rst out", 32'(bus.RGBStr_o), 32'({3'b000, IDLE2[22:0]}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-rst out", 32'(bus.RGBStr_o), 32'd0);
        chk("mid-rst locked", 32'(bus.locked_o), 32'd0);
        chk("mid-rst skew", 32'(bus.skew_o), 32'd0);
        chk("mid-rst err", 32'(bus.err_o), 32'd0);
        do_reset();
        run_stream("relock12", 12, 2'b01, 3'b110, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
